// File: rtl/cylon_gen.sv
// cylon_gen: parametrised LED pattern generator (bounce, walk, dual-eye, blink) with lamp test.
// Latency: q and step update one clock after the prescaler carry (tick); step is a 1-clock pulse.
// Backpressure: none; i_freeze holds prescaler, position state, q, and forces step low.
//
// Ports:
//   i_clock  - fabric clock
//   i_reset  - synchronous, active-high reset (overrides i_freeze)
//   i_rate   - step speed, 0 slowest .. 3 fastest; period 2^MXPRE/(rate+1) clocks
//   i_mode   - 0 bounce, 1 walk, 2 dual-eye, 3 blink; sampled only on a tick
//   i_freeze - 1 = hold everything, no steps
//   o_q      - registered LED pattern
//   o_step   - registered pulse on the cycle o_q advances
module cylon_gen #(
  parameter int WIDTH     = 12,
  parameter int MXPRE     = 21,
  parameter bit LAMP_TEST = 1'b1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [1:0]       i_rate,
  input  logic [1:0]       i_mode,
  input  logic             i_freeze,
  output logic [WIDTH-1:0] o_q,
  output logic             o_step
);

  localparam int PW = $clog2(WIDTH);
  localparam logic [PW-1:0]    P_ZERO = '0;
  localparam logic [PW-1:0]    P_ONE  = PW'(1);
  localparam logic [PW-1:0]    P_LAST = PW'(WIDTH - 1);
  localparam logic [PW-1:0]    P_PEN  = PW'(WIDTH - 2);
  localparam logic [WIDTH-1:0] Q_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] Q_INIT = LAMP_TEST ? {WIDTH{1'b1}} : Q_ONE;

  typedef enum logic [0:0] {S_LAMP = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state;
  logic [MXPRE-1:0] r_pre;
  logic [PW-1:0]   r_pos;
  logic            r_dir;    // 0 = up, 1 = down
  logic            r_phase;  // blink phase, 1 = all on
  logic [1:0]      r_mode;

  logic [MXPRE:0]  w_sum;
  logic            w_tick;
  logic            w_restart;
  logic [PW-1:0]   w_pos_nx;
  logic            w_dir_nx;
  logic            w_phase_nx;
  logic [WIDTH-1:0] w_q_nx;

  // Pattern for a given mode/position/phase.
  function automatic logic [WIDTH-1:0] f_pat(input logic [1:0] m,
                                             input logic [PW-1:0] p,
                                             input logic ph);
    logic [WIDTH-1:0] v;
    v = '0;
    case (m)
      2'd3:    v = ph ? {WIDTH{1'b1}} : '0;
      2'd2:    v = (Q_ONE << p) | (Q_ONE << (P_LAST - p));
      default: v = Q_ONE << p;
    endcase
    return v;
  endfunction

  // Carry out of the add is the tick; no compare, so every rate wraps cleanly.
  assign w_sum  = {1'b0, r_pre} + (MXPRE+1)'(i_rate) + (MXPRE+1)'(1);
  assign w_tick = w_sum[MXPRE];

  always_comb begin
    w_restart  = (r_state == S_LAMP) || (i_mode != r_mode);
    w_pos_nx   = r_pos;
    w_dir_nx   = r_dir;
    w_phase_nx = r_phase;
    if (w_restart) begin
      w_pos_nx   = P_ZERO;
      w_dir_nx   = 1'b0;
      w_phase_nx = 1'b1;
    end else begin
      case (r_mode)
        2'd1: w_pos_nx = (r_pos == P_LAST) ? P_ZERO : r_pos + P_ONE;
        2'd3: w_phase_nx = ~r_phase;
        default: begin
          // Bounce: turn around at the ends so each endpoint shows once per pass.
          if (!r_dir) begin
            if (r_pos == P_LAST) begin
              w_pos_nx = P_PEN;
              w_dir_nx = 1'b1;
            end else begin
              w_pos_nx = r_pos + P_ONE;
            end
          end else begin
            if (r_pos == P_ZERO) begin
              w_pos_nx = P_ONE;
              w_dir_nx = 1'b0;
            end else begin
              w_pos_nx = r_pos - P_ONE;
            end
          end
        end
      endcase
    end
    // On a tick the mode register takes i_mode, so the new pattern uses it.
    w_q_nx = f_pat(i_mode, w_pos_nx, w_phase_nx);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= LAMP_TEST ? S_LAMP : S_RUN;
      r_pre   <= '0;
      r_pos   <= P_ZERO;
      r_dir   <= 1'b0;
      r_phase <= 1'b1;
      r_mode  <= 2'd0;
      o_step  <= 1'b0;
      o_q     <= Q_INIT;
    end else if (i_freeze) begin
      o_step <= 1'b0;
    end else begin
      r_pre  <= w_sum[MXPRE-1:0];
      o_step <= w_tick;
      if (w_tick) begin
        r_state <= S_RUN;
        r_mode  <= i_mode;
        r_pos   <= w_pos_nx;
        r_dir   <= w_dir_nx;
        r_phase <= w_phase_nx;
        o_q     <= w_q_nx;
      end
    end
  end

endmodule

// File: tb/tb_cylon_gen.sv
module tb_cylon_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, frz;
  logic [1:0]  rate, m0, m1, m2;
  logic [11:0] q0, q2;
  logic [4:0]  q1;
  logic        s0, s1, s2;
  int          n_checks = 0;
  int          n_err    = 0;

  // 12 LEDs with lamp test, 5 LEDs without, 12 LEDs without.
  cylon_gen #(.WIDTH(12), .MXPRE(3), .LAMP_TEST(1'b1)) u0 (
    .i_clock(clk), .i_reset(rst), .i_rate(rate), .i_mode(m0), .i_freeze(frz),
    .o_q(q0), .o_step(s0));
  cylon_gen #(.WIDTH(5), .MXPRE(3), .LAMP_TEST(1'b0)) u1 (
    .i_clock(clk), .i_reset(rst), .i_rate(rate), .i_mode(m1), .i_freeze(frz),
    .o_q(q1), .o_step(s1));
  cylon_gen #(.WIDTH(12), .MXPRE(3), .LAMP_TEST(1'b0)) u2 (
    .i_clock(clk), .i_reset(rst), .i_rate(rate), .i_mode(m2), .i_freeze(frz),
    .o_q(q2), .o_step(s2));

  logic [11:0] bnc [0:23] = '{12'h001, 12'h002, 12'h004, 12'h008, 12'h010, 12'h020,
                              12'h040, 12'h080, 12'h100, 12'h200, 12'h400, 12'h800,
                              12'h400, 12'h200, 12'h100, 12'h080, 12'h040, 12'h020,
                              12'h010, 12'h008, 12'h004, 12'h002, 12'h001, 12'h002};
  logic [11:0] dual [0:12] = '{12'h801, 12'h402, 12'h204, 12'h108, 12'h090, 12'h060,
                               12'h060, 12'h090, 12'h108, 12'h204, 12'h402, 12'h801,
                               12'h402};
  logic [4:0]  eye5 [0:7] = '{5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h0A, 5'h04, 5'h0A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int ns;
    logic [11:0] ew;
    rst = 1'b1; frz = 1'b0; rate = 2'd0; m0 = 2'd0; m1 = 2'd2; m2 = 2'd1;
    repeat (2) @(negedge clk);
    chk("rst_q0", q0, 12'hFFF);
    chk("rst_step0", s0, 1'b0);
    chk("rst_q1", q1, 5'h01);
    chk("rst_q2", q2, 12'h001);

    // Lamp test lasts exactly 8 clocks, then bounce starts at 001.
    rst = 1'b0;
    repeat (7) @(negedge clk);
    chk("lamp_hold", q0, 12'hFFF);
    chk("lamp_nostep", s0, 1'b0);
    for (int t = 1; t <= 24; t++) begin
      @(negedge clk);
      chk("bounce_q", q0, bnc[t-1]);
      chk("bounce_step", s0, 1'b1);
      ew = 12'h001 << ((t - 1) % 12);
      chk("walk_q", q2, ew);
      if (t <= 8) chk("eye5_q", q1, eye5[t-1]);
      if (t < 24) begin
        @(negedge clk);
        chk("step_pulse", s0, 1'b0);
        repeat (6) @(negedge clk);
      end
    end

    // Mode change mid-interval only shows at the next tick.
    m0 = 2'd2;
    repeat (3) @(negedge clk);
    chk("mode_pending", q0, 12'h002);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      chk("dual_q", q0, dual[k]);
      chk("dual_step", s0, 1'b1);
      if (k < 12) repeat (7) @(negedge clk);
    end

    // Blink, then switch back to bounce mid-interval.
    m0 = 2'd3;
    repeat (8) @(negedge clk);
    chk("blink_on", q0, 12'hFFF);
    repeat (8) @(negedge clk);
    chk("blink_off", q0, 12'h000);
    repeat (8) @(negedge clk);
    chk("blink_on2", q0, 12'hFFF);
    m0 = 2'd0;
    repeat (3) @(negedge clk);
    chk("blink_pending", q0, 12'hFFF);
    repeat (5) @(negedge clk);
    chk("back_bounce", q0, 12'h001);

    // Freeze across a would-be tick; nothing lost on release.
    repeat (3) @(negedge clk);
    frz = 1'b1;
    ns = 0;
    repeat (20) begin
      @(negedge clk);
      if (s0) ns++;
    end
    chk("frz_steps", ns, 0);
    chk("frz_q", q0, 12'h001);
    frz = 1'b0;
    repeat (4) @(negedge clk);
    chk("frz_resume_hold", q0, 12'h001);
    @(negedge clk);
    chk("frz_resume_q", q0, 12'h002);
    chk("frz_resume_step", s0, 1'b1);

    // Step counts over 16 clocks for each faster rate.
    rate = 2'd3; ns = 0;
    repeat (16) begin @(negedge clk); if (s0) ns++; end
    chk("rate3_steps", ns, 8);
    rate = 2'd2; ns = 0;
    repeat (16) begin @(negedge clk); if (s0) ns++; end
    chk("rate2_steps", ns, 6);
    rate = 2'd1; ns = 0;
    repeat (16) begin @(negedge clk); if (s0) ns++; end
    chk("rate1_steps", ns, 4);
    rate = 2'd0;

    // Reset mid-run wins over freeze and reruns the lamp test.
    rst = 1'b1; frz = 1'b1;
    @(negedge clk);
    chk("rst2_q0", q0, 12'hFFF);
    chk("rst2_step", s0, 1'b0);
    chk("rst2_q2", q2, 12'h001);
    chk("rst2_q1", q1, 5'h01);
    rst = 1'b0; frz = 1'b0;
    repeat (7) @(negedge clk);
    chk("lamp2_hold", q0, 12'hFFF);
    @(negedge clk);
    chk("lamp2_end", q0, 12'h001);
    chk("lamp2_step", s0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cylon_gen.md
# cylon_gen

Parametrised LED pattern generator; successor to the fixed 12-bit, single-mode cylon. Drives a front-panel or debug LED bank of configurable width. Supports:
- four selectable display modes (bounce, walk, dual-eye, blink);
- a carry-based prescaler that ticks correctly at every rate setting;
- an optional power-on lamp test;
- a freeze input.

Sits in the board-status logic, clocked from the fabric clock, with outputs registered for direct connection to LED drivers.

## Interface
- WIDTH, 12, number of LEDs; legal range 2..32
- MXPRE, 21, prescaler width; step period is 2^MXPRE/(rate+1) clocks
- LAMP_TEST, 1, 1 = show all-ones for one step period after reset; 0 = skip
- clock  in  1  fabric clock; one clock domain; reset is synchronous and active-high
- reset  in  1  synchronous, active-high reset
- rate  in  2  step speed, 0 slowest .. 3 fastest
- mode  in  2  0 bounce, 1 walk, 2 dual-eye, 3 blink
- freeze  in  1  1 = hold prescaler, state and q
- q  out  WIDTH  registered LED pattern
- step  out  1  one-clock pulse, registered, asserted on the cycle q advances

## Operation
- State machine has two states, LAMP and RUN.
  - Reset enters LAMP when LAMP_TEST=1; otherwise it enters RUN.
  - LAMP moves to RUN on the first tick. LAMP ignores mode.
- Prescaler: MXPRE-bit register plus carry. Each unfrozen cycle: {carry, pre} <= pre + rate + 1. tick = carry out of that add. No equality compare is used, so every rate value produces ticks.
- Position state:
  - pos: 0..WIDTH-1, width clog2(WIDTH).
  - dir: 0 = up, 1 = down.
  - phase: 1 bit, used by blink only.
- Mode 0, bounce:
  - pos sequence 0,1,...,W-1,W-2,...,1,0,1,... Each endpoint is shown exactly once per pass; period is 2W-2 steps.
  - q = onehot(pos).
- Mode 1, walk:
  - pos increments and wraps from W-1 to 0.
  - q = onehot(pos).
- Mode 2, dual-eye:
  - pos follows the bounce sequence.
  - q = onehot(pos) | onehot(W-1-pos). The eyes cross, so an odd WIDTH shows a single lit bit at the centre.
- Mode 3, blink:
  - phase toggles each tick.
  - q = all ones when phase=1, all zeros when phase=0.
- Mode change:
  - The mode register samples the mode input only on a tick.
  - When the sampled value differs from the current mode, state restarts: pos=0, dir=up, phase=1. q shows the new mode's initial pattern.
  - A mode change between ticks has no visible effect until the next tick.
- freeze=1:
  - Prescaler, pos, dir, phase and q all hold. step=0.
  - On release, counting resumes from the held prescaler value; nothing is skipped.
- Reset mid-operation: all state returns to reset values on the next clock edge, regardless of freeze.

## Timing
- Reset values:
  - pre=0, pos=0, dir=up, phase=1, step=0, mode register=0.
  - q = all ones if LAMP_TEST=1, else onehot(0).
- tick is combinational from pre. On a tick cycle, the edge loads the next pos/dir/phase and the next q, and sets step=1. Latency from carry to a visible q change is one clock.
- Tick spacing from reset release:
  - rate 0: 2^MXPRE clocks.
  - rate 1: 2^(MXPRE-1) clocks.
  - rate 3: 2^(MXPRE-2) clocks.
  - rate 2: ticks spaced irregularly, averaging 3 ticks per 2^MXPRE clocks.
- rate may change on any cycle; it takes effect on the next add.
- LAMP duration is exactly the first tick interval. The first RUN pattern is the mode's initial pattern: bounce/walk/dual = onehot(0) or onehot(0)|onehot(W-1); blink = all ones.
- Simultaneous tick and mode change: the restart wins; pos=0 and the new pattern load.
- Simultaneous tick and freeze=1: freeze wins; no advance, no step.

## Test plan
- WIDTH=12, MXPRE=3, rate=0, mode=0 -> q=FFF for 8 clocks after reset release, then 001,002,...,800,400,...,002,001,002. step pulses every 8 clocks; 800 and 001 each appear once per pass.
- MXPRE=3, rate=3 -> step every 2 clocks. rate=2 -> exactly 3 steps per 8 clocks. rate=1 -> step every 4 clocks.
- mode=1, WIDTH=12, LAMP_TEST=0 -> q=001 immediately after reset, then 002,...,800,001 (wrap with no reversal).
- mode=2, WIDTH=12 -> 801,402,204,108,090,060,060,090,...,801,402. WIDTH=5 -> 11,0A,04,0A,11.
- mode=3 -> q alternates 000/FFF each tick. Switching mode 3->0 mid-interval -> no change until the next tick, then q=001.
- freeze=1 for 20 clocks mid-run -> q and step frozen, no steps lost after release. reset asserted mid-run -> q=FFF on the next edge and LAMP re-runs.
